// File: rtl/miller_frame_assembler_pkg.sv
// Shared Miller defines: frame FSM encoding, frame bit constants and the
// default byte limit used by the decoder chain.
package miller_frame_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } frame_state_t;

  localparam int DATA_BITS         = 8;
  localparam int FRAME_BITS        = 9;
  localparam int SHORT_BITS        = 7;
  localparam int DEFAULT_MAX_BYTES = 32;

  // Odd-parity bit that must accompany a data byte
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/miller_frame_assembler.sv
// Assembles decoded Miller bits into bytes with odd-parity checking, handles
// 7-bit short frames, frame errors and byte-count saturation.
module miller_frame_assembler
  import miller_frame_assembler_pkg::*;
#(
  parameter int MAX_BYTES = DEFAULT_MAX_BYTES
) (
  input  logic       in_clk,
  input  logic       in_PoR,
  input  logic       in_sof,
  input  logic       in_bit_valid,
  input  logic       in_bit,
  input  logic       in_eof,
  output logic [7:0] out_byte,
  output logic       out_byte_valid,
  output logic       out_parity_err,
  output logic       out_short_frame,
  output logic       out_frame_err,
  output logic       out_frame_done,
  output logic [5:0] out_byte_count
);

  frame_state_t state;
  logic [3:0]   bit_count;
  logic [7:0]   shift_reg;
  logic         parity_q;
  logic         eof_d;
  logic         eof_rise;

  // EoF is a sticky level, so only its rising edge ends a frame
  assign eof_rise = in_eof & ~eof_d;

  // Frame FSM with all outputs registered; state advances on the falling edge
  always_ff @(negedge in_clk or negedge in_PoR) begin
    if (!in_PoR) begin
      state           <= ST_IDLE;
      bit_count       <= '0;
      shift_reg       <= '0;
      parity_q        <= 1'b0;
      eof_d           <= 1'b0;
      out_byte        <= '0;
      out_byte_valid  <= 1'b0;
      out_parity_err  <= 1'b0;
      out_short_frame <= 1'b0;
      out_frame_err   <= 1'b0;
      out_frame_done  <= 1'b0;
      out_byte_count  <= '0;
    end else begin
      eof_d          <= in_eof;
      out_byte_valid <= 1'b0;
      out_frame_done <= 1'b0;

      if (in_sof && state != ST_DONE) begin
        state           <= ST_DATA;
        bit_count       <= '0;
        shift_reg       <= '0;
        parity_q        <= 1'b0;
        out_byte_count  <= '0;
        out_short_frame <= 1'b0;
        out_frame_err   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end

          ST_DATA: begin
            if (eof_rise) begin
              if (bit_count == 4'(SHORT_BITS) && out_byte_count == '0) begin
                out_byte        <= {1'b0, shift_reg[6:0]};
                out_byte_valid  <= 1'b1;
                out_parity_err  <= 1'b0;
                out_short_frame <= 1'b1;
              end else if (bit_count != '0) begin
                out_frame_err <= 1'b1;
              end
              state <= ST_DONE;
            end else if (in_bit_valid) begin
              shift_reg[bit_count[2:0]] <= in_bit;
              bit_count                 <= bit_count + 4'd1;
              if (bit_count == 4'(DATA_BITS - 1)) begin
                state <= ST_PARITY;
              end
            end
          end

          ST_PARITY: begin
            if (bit_count == 4'(FRAME_BITS)) begin
              if (out_byte_count >= 6'(MAX_BYTES)) begin
                out_frame_err <= 1'b1;
              end else begin
                out_byte       <= shift_reg;
                out_byte_valid <= 1'b1;
                out_parity_err <= parity_q;
                out_byte_count <= out_byte_count + 6'd1;
              end
              bit_count <= '0;
              state     <= eof_rise ? ST_DONE : ST_DATA;
            end else if (eof_rise) begin
              out_frame_err <= 1'b1;
              state         <= ST_DONE;
            end else if (in_bit_valid) begin
              parity_q  <= (in_bit != odd_parity(shift_reg));
              bit_count <= bit_count + 4'd1;
            end
          end

          ST_DONE: begin
            out_frame_done <= 1'b1;
            state          <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_miller_frame_assembler.sv
// Scoreboard bench for the Miller frame assembler: stimulus pushes expected
// byte and end-of-frame events, a monitor pops them as the DUT pulses.
module tb_miller_frame_assembler;

  logic       in_clk;
  logic       in_PoR;
  logic       in_sof;
  logic       in_bit_valid;
  logic       in_bit;
  logic       in_eof;
  logic [7:0] out_byte;
  logic       out_byte_valid;
  logic       out_parity_err;
  logic       out_short_frame;
  logic       out_frame_err;
  logic       out_frame_done;
  logic [5:0] out_byte_count;

  int errors = 0;
  int checks = 0;
  logic eof_lvl = 1'b0;

  // {parity_err, byte}
  logic [8:0] byte_q[$];
  // {short_frame, frame_err, byte_count}
  logic [7:0] frame_q[$];

  miller_frame_assembler #(.MAX_BYTES(2)) dut (
    .in_clk          (in_clk),
    .in_PoR          (in_PoR),
    .in_sof          (in_sof),
    .in_bit_valid    (in_bit_valid),
    .in_bit          (in_bit),
    .in_eof          (in_eof),
    .out_byte        (out_byte),
    .out_byte_valid  (out_byte_valid),
    .out_parity_err  (out_parity_err),
    .out_short_frame (out_short_frame),
    .out_frame_err   (out_frame_err),
    .out_frame_done  (out_frame_done),
    .out_byte_count  (out_byte_count)
  );

  // Free-running clock
  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one clock period of inputs, changing them on the rising edge
  task automatic applyStimulus(input logic sof, input logic bv, input logic b, input logic eof);
    @(posedge in_clk);
    in_sof       = sof;
    in_bit_valid = bv;
    in_bit       = b;
    in_eof       = eof;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, eof_lvl);
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b0, 1'b1, b, eof_lvl);
    idle(2);
  endtask

  task automatic startFrame();
    applyStimulus(1'b1, 1'b0, 1'b0, eof_lvl);
    idle(2);
  endtask

  // Send a byte plus parity; expect a byte event unless it will overflow
  task automatic sendByte(input logic [7:0] b, input logic p, input logic expect_out);
    if (expect_out) byte_q.push_back({(p != ~^b), b});
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(p);
    idle(2);
  endtask

  task automatic endFrame(input logic short_f, input logic err_f, input logic [5:0] cnt);
    frame_q.push_back({short_f, err_f, cnt});
    eof_lvl = 1'b1;
    idle(4);
    eof_lvl = 1'b0;
    idle(3);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_byte"},   out_byte, 8'h00);
    checkOutput({tag, "_valid"},  {7'd0, out_byte_valid}, 8'h00);
    checkOutput({tag, "_perr"},   {7'd0, out_parity_err}, 8'h00);
    checkOutput({tag, "_short"},  {7'd0, out_short_frame}, 8'h00);
    checkOutput({tag, "_ferr"},   {7'd0, out_frame_err}, 8'h00);
    checkOutput({tag, "_done"},   {7'd0, out_frame_done}, 8'h00);
    checkOutput({tag, "_count"},  {2'd0, out_byte_count}, 8'h00);
  endtask

  // Monitor: compare every output pulse with the oldest expected event
  always @(posedge in_clk) begin
    if (in_PoR) begin
      if (out_byte_valid) begin
        if (byte_q.size() == 0) begin
          checkOutput("unexpected_byte_valid", out_byte, 8'hxx);
        end else begin
          logic [8:0] e;
          e = byte_q.pop_front();
          checkOutput("byte_value", out_byte, e[7:0]);
          checkOutput("byte_parity_err", {7'd0, out_parity_err}, {7'd0, e[8]});
        end
      end
      if (out_frame_done) begin
        if (frame_q.size() == 0) begin
          checkOutput("unexpected_frame_done", {2'd0, out_byte_count}, 8'hxx);
        end else begin
          logic [7:0] f;
          f = frame_q.pop_front();
          checkOutput("frame_short", {7'd0, out_short_frame}, {7'd0, f[7]});
          checkOutput("frame_err", {7'd0, out_frame_err}, {7'd0, f[6]});
          checkOutput("frame_count", {2'd0, out_byte_count}, {2'd0, f[5:0]});
        end
      end
    end
  end

  logic [7:0] short_bits;

  initial begin
    in_PoR = 1'b0;
    in_sof = 1'b0;
    in_bit_valid = 1'b0;
    in_bit = 1'b0;
    in_eof = 1'b0;
    repeat (3) @(posedge in_clk);
    checkResetOutputs("por");
    in_PoR = 1'b1;
    idle(3);

    $display("[TB] byte 0x93 with good parity");
    startFrame();
    sendByte(8'h93, 1'b1, 1'b1);
    endFrame(1'b0, 1'b0, 6'd1);

    $display("[TB] byte 0x93 with bad parity");
    startFrame();
    sendByte(8'h93, 1'b0, 1'b1);
    endFrame(1'b0, 1'b0, 6'd1);

    $display("[TB] 7-bit short frame 0x26");
    startFrame();
    short_bits = 8'h26;
    byte_q.push_back({1'b0, 8'h26});
    for (int i = 0; i < 7; i++) sendBit(short_bits[i]);
    endFrame(1'b1, 1'b0, 6'd0);

    $display("[TB] overflow past two bytes");
    startFrame();
    sendByte(8'h11, 1'b1, 1'b1);
    sendByte(8'h22, 1'b0, 1'b1);
    sendByte(8'h33, 1'b1, 1'b0);
    endFrame(1'b0, 1'b1, 6'd2);

    $display("[TB] reset mid-byte, then 0xA5");
    startFrame();
    for (int i = 0; i < 4; i++) sendBit(i[0]);
    @(posedge in_clk);
    in_PoR = 1'b0;
    @(posedge in_clk);
    checkResetOutputs("midreset");
    in_PoR = 1'b1;
    idle(3);
    startFrame();
    sendByte(8'hA5, 1'b1, 1'b1);
    endFrame(1'b0, 1'b0, 6'd1);

    $display("[TB] bit strobe coincident with EoF after 3 bits");
    startFrame();
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    frame_q.push_back({1'b0, 1'b1, 6'd0});
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    idle(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    $display("[TB] SoF restart mid-byte");
    startFrame();
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    startFrame();
    sendByte(8'h5A, 1'b1, 1'b1);
    endFrame(1'b0, 1'b0, 6'd1);

    idle(10);
    checkOutput("byte_events_left", 8'(byte_q.size()), 8'd0);
    checkOutput("frame_events_left", 8'(frame_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
